// File: rtl/mac_axi_master_if.sv
// AXI-4 bus bundle between the MAC job initiator and the accelerator slave.
// Handshake rule on every channel: a beat transfers on a rising edge where
// VALID and READY are both high; VALID, once raised, is held with stable
// payload until that edge, and never waits on READY.
interface mac_axi_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [7:0]          M_AXI_AWLEN;
  logic [2:0]          M_AXI_AWSIZE;
  logic [1:0]          M_AXI_AWBURST;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WLAST;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic [7:0]          M_AXI_ARLEN;
  logic [2:0]          M_AXI_ARSIZE;
  logic [1:0]          M_AXI_ARBURST;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RLAST;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/mac_axi_master.sv
// mac_axi_master: runs one MAC job over AXI-4 -- 32-beat data burst to 0x00,
// bias write to 0x8C, start write to 0x80, status polling at 0x80 and the
// result read at 0x81. All AXI outputs come straight from flops.
module mac_axi_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 8,
  parameter int POLL_MAX           = 64,
  parameter int POLL_GAP           = 8
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESET,
  input  logic                    ld_we,
  input  logic [4:0]              ld_addr,
  input  logic [31:0]             ld_data,
  input  logic [15:0]             bias_in,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             result,
  output logic                    err_resp,
  output logic                    err_timeout,
  output logic [3:0]              dbg_state,
  mac_axi_master_if.master        m_axi
);
  localparam int DW  = C_M_AXI_DATA_WIDTH;
  localparam int AW  = C_M_AXI_ADDR_WIDTH;
  localparam int PCW = $clog2(POLL_MAX + 1);
  localparam int GCW = $clog2(POLL_GAP + 1);

  typedef enum logic [3:0] {
    IDLE, D_AW, D_B, BI_AW, BI_B, ST_AW, ST_B, P_AR, P_R, P_GAP, R_AR, R_R, FIN
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      beat_q, beat_d;
  logic [PCW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [GCW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0]     bias_q, bias_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
  logic            bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic [AW-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [7:0]      awlen_q, awlen_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [15:0]     result_q, result_d;
  logic            err_resp_q, err_resp_d, err_timeout_q, err_timeout_d;

  // Job buffer: not reset, so a preloaded job survives a bus reset.
  logic [DW-1:0]   buf_mem [32];
  logic            start_acc;
  logic            unused_r;

  assign start_acc = start && (state_q == IDLE);
  assign unused_r  = ^{m_axi.M_AXI_RLAST, m_axi.M_AXI_RDATA[DW-1:16]};

  // Local buffer load; frozen while a job runs or is being started.
  always_ff @(posedge M_AXI_ACLK) begin
    if (ld_we && !busy_q && !start_acc) buf_mem[ld_addr] <= ld_data;
  end

  // Next-state and next-output logic for the job sequencer.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    poll_cnt_d    = poll_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    bias_d        = bias_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    wlast_d       = wlast_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    awlen_d       = awlen_q;
    wdata_d       = wdata_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    result_d      = result_q;
    err_resp_d    = err_resp_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      IDLE: if (start) begin
        bias_d        = bias_in;
        err_resp_d    = 1'b0;
        err_timeout_d = 1'b0;
        poll_cnt_d    = '0;
        gap_cnt_d     = '0;
        beat_d        = '0;
        busy_d        = 1'b1;
        awvalid_d     = 1'b1;
        wvalid_d      = 1'b1;
        awaddr_d      = '0;
        awlen_d       = 8'd31;
        wdata_d       = buf_mem[0];
        wlast_d       = 1'b0;
        state_d       = D_AW;
      end
      D_AW, BI_AW, ST_AW: begin
        if (awvalid_q && m_axi.M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.M_AXI_WREADY) begin
          if (wlast_q) begin
            wvalid_d = 1'b0;
          end else begin
            beat_d  = beat_q + 5'd1;
            wdata_d = buf_mem[beat_d];
            wlast_d = (beat_d == 5'd31);
          end
        end
        // Leave for the response only once both address and last beat are gone.
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          case (state_q)
            D_AW:    state_d = D_B;
            BI_AW:   state_d = BI_B;
            default: state_d = ST_B;
          endcase
        end
      end
      D_B, BI_B, ST_B: if (m_axi.M_AXI_BVALID) begin
        bready_d = 1'b0;
        if (m_axi.M_AXI_BRESP != 2'b00) begin
          err_resp_d = 1'b1;
          done_d     = 1'b1;
          state_d    = FIN;
        end else begin
          case (state_q)
            D_B: begin
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              awaddr_d  = AW'(8'h8C);
              awlen_d   = 8'd0;
              wdata_d   = DW'(bias_q);
              wlast_d   = 1'b1;
              state_d   = BI_AW;
            end
            BI_B: begin
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              awaddr_d  = AW'(8'h80);
              awlen_d   = 8'd0;
              wdata_d   = DW'(1);
              wlast_d   = 1'b1;
              state_d   = ST_AW;
            end
            default: begin
              arvalid_d = 1'b1;
              araddr_d  = AW'(8'h80);
              state_d   = P_AR;
            end
          endcase
        end
      end
      P_AR, R_AR: if (m_axi.M_AXI_ARREADY) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = (state_q == P_AR) ? P_R : R_R;
      end
      P_R: if (m_axi.M_AXI_RVALID) begin
        rready_d   = 1'b0;
        poll_cnt_d = poll_cnt_q + 1'b1;
        if (m_axi.M_AXI_RRESP != 2'b00) begin
          err_resp_d = 1'b1;
          done_d     = 1'b1;
          state_d    = FIN;
        end else if (m_axi.M_AXI_RDATA[1]) begin
          arvalid_d = 1'b1;
          araddr_d  = AW'(8'h81);
          state_d   = R_AR;
        end else if (poll_cnt_d == PCW'(POLL_MAX)) begin
          // The result register persists, so it is still worth reading.
          err_timeout_d = 1'b1;
          arvalid_d     = 1'b1;
          araddr_d      = AW'(8'h81);
          state_d       = R_AR;
        end else begin
          gap_cnt_d = GCW'(POLL_GAP - 1);
          state_d   = P_GAP;
        end
      end
      P_GAP: begin
        if (gap_cnt_q == '0) begin
          arvalid_d = 1'b1;
          araddr_d  = AW'(8'h80);
          state_d   = P_AR;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      R_R: if (m_axi.M_AXI_RVALID) begin
        rready_d = 1'b0;
        result_d = m_axi.M_AXI_RDATA[15:0];
        if (m_axi.M_AXI_RRESP != 2'b00) err_resp_d = 1'b1;
        done_d  = 1'b1;
        state_d = FIN;
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any outstanding transaction.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      poll_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      bias_q        <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      wlast_q       <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      awlen_q       <= '0;
      wdata_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      err_resp_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      poll_cnt_q    <= poll_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      bias_q        <= bias_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      wlast_q       <= wlast_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
      awlen_q       <= awlen_d;
      wdata_q       <= wdata_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      result_q      <= result_d;
      err_resp_q    <= err_resp_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign err_resp    = err_resp_q;
  assign err_timeout = err_timeout_q;
  assign dbg_state   = state_q;

  assign m_axi.M_AXI_AWADDR  = awaddr_q;
  assign m_axi.M_AXI_AWLEN   = awlen_q;
  assign m_axi.M_AXI_AWSIZE  = 3'b010;
  assign m_axi.M_AXI_AWBURST = 2'b01;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WLAST   = wlast_q;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARADDR  = araddr_q;
  assign m_axi.M_AXI_ARLEN   = 8'd0;
  assign m_axi.M_AXI_ARSIZE  = 3'b010;
  assign m_axi.M_AXI_ARBURST = 2'b01;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_mac_axi_master.sv
// Bench for mac_axi_master: AXI slave BFM, expected-event queues filled by
// the driver, and a monitor that pops and compares on every handshake/done.
module tb_mac_axi_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        ld_we;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [15:0] bias_in;
  logic        start;
  logic        busy, done, err_resp, err_timeout;
  logic [15:0] result;
  logic [3:0]  dbg_state;

  always #5 clk = ~clk;

  mac_axi_master_if #(.ADDR_W(8), .DATA_W(32)) axi ();

  mac_axi_master #(
    .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(8), .POLL_MAX(64), .POLL_GAP(8)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .bias_in(bias_in), .start(start),
    .busy(busy), .done(done), .result(result),
    .err_resp(err_resp), .err_timeout(err_timeout),
    .dbg_state(dbg_state), .m_axi(axi)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // Expected events
  logic [15:0] aw_exp_q[$];   // {awaddr, awlen}
  logic [32:0] w_exp_q[$];    // {wlast, wdata}
  logic [7:0]  ar_exp_q[$];   // araddr
  logic [17:0] done_exp_q[$]; // {err_resp, err_timeout, result}
  logic [31:0] model_buf [32];

  // Slave BFM configuration and state
  int          aw_delay = 0;
  bit          w_rand = 0;
  bit          b_err_data = 0;
  int          done_at = 1;        // status done bit from this poll on; 0 = never
  logic [15:0] res_val = 16'h0;
  int          aw_cnt;
  bit          aw_got, wl_got, b_pend, r_pend;
  logic [7:0]  cur_len, rd_addr;
  int          poll_n;

  // Slave BFM: drives channel inputs at the falling edge; address is only
  // taken with write data present, and data never runs ahead of its address.
  initial begin : slave
    axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0;
    axi.M_AXI_BVALID = 1'b0;  axi.M_AXI_BRESP = 2'b00;
    axi.M_AXI_ARREADY = 1'b0; axi.M_AXI_RVALID = 1'b0;
    axi.M_AXI_RDATA = '0;     axi.M_AXI_RRESP = 2'b00; axi.M_AXI_RLAST = 1'b0;
    aw_cnt = 0; aw_got = 0; wl_got = 0; b_pend = 0; r_pend = 0;
    cur_len = 0; rd_addr = 0; poll_n = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0; axi.M_AXI_BVALID = 1'b0;
        axi.M_AXI_ARREADY = 1'b0; axi.M_AXI_RVALID = 1'b0; axi.M_AXI_RLAST = 1'b0;
        aw_cnt = 0; aw_got = 0; wl_got = 0; b_pend = 0; r_pend = 0;
      end else begin
        axi.M_AXI_BVALID = b_pend;
        axi.M_AXI_BRESP  = (b_err_data && cur_len == 8'd31) ? 2'b10 : 2'b00;
        if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) b_pend = 0;
        axi.M_AXI_RVALID = r_pend;
        axi.M_AXI_RLAST  = r_pend;
        if (rd_addr == 8'h80)
          axi.M_AXI_RDATA = (done_at != 0 && poll_n >= done_at) ? 32'h2 : 32'h0;
        else
          axi.M_AXI_RDATA = {16'hFFFF, res_val};
        if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) r_pend = 0;
        axi.M_AXI_ARREADY = axi.M_AXI_ARVALID;
        if (axi.M_AXI_ARVALID) begin
          r_pend  = 1;
          rd_addr = axi.M_AXI_ARADDR;
          if (rd_addr == 8'h80) poll_n++;
        end
        if (axi.M_AXI_AWVALID && axi.M_AXI_WVALID && !aw_got) begin
          if (aw_cnt >= aw_delay) axi.M_AXI_AWREADY = 1'b1;
          else begin axi.M_AXI_AWREADY = 1'b0; aw_cnt++; end
        end else begin
          axi.M_AXI_AWREADY = 1'b0;
        end
        axi.M_AXI_WREADY = (aw_got || axi.M_AXI_AWREADY) && axi.M_AXI_WVALID &&
                           (w_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
        if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) begin
          aw_got = 1; aw_cnt = 0; cur_len = axi.M_AXI_AWLEN;
          if (axi.M_AXI_AWADDR == 8'h80) poll_n = 0;
        end
        if (axi.M_AXI_WVALID && axi.M_AXI_WREADY && axi.M_AXI_WLAST) wl_got = 1;
        if (aw_got && wl_got) begin b_pend = 1; aw_got = 0; wl_got = 0; end
      end
    end
  end

  // Monitor state
  int          done_n = 0;
  int          w_beats = 0;
  logic        p_av, p_ar, p_wv, p_wr, p_wl, p_done;
  logic [7:0]  p_aa, last_ar;
  logic [31:0] p_wd;
  bit          gap_on;
  int          gap_n;

  // Monitor: samples just after the falling edge, when both sides are settled.
  initial begin : monitor
    p_av = 0; p_ar = 0; p_wv = 0; p_wr = 0; p_wl = 0; p_done = 0;
    p_aa = 0; p_wd = 0; last_ar = 0; gap_on = 0; gap_n = 0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        p_av = 0; p_wv = 0; p_done = 0; gap_on = 0;
      end else begin
        if (p_av && !p_ar) check("aw_hold", {axi.M_AXI_AWVALID, axi.M_AXI_AWADDR}, {1'b1, p_aa});
        if (p_wv && !p_wr)
          check("w_hold", {axi.M_AXI_WVALID, axi.M_AXI_WLAST, axi.M_AXI_WDATA}, {1'b1, p_wl, p_wd});
        if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) begin
          if (aw_exp_q.size() == 0) fail_now("aw_unexpected");
          else check("aw", {axi.M_AXI_AWADDR, axi.M_AXI_AWLEN}, aw_exp_q.pop_front());
        end
        if (axi.M_AXI_WVALID && axi.M_AXI_WREADY) begin
          w_beats++;
          if (w_exp_q.size() == 0) fail_now("w_unexpected");
          else check("w_beat", {axi.M_AXI_WLAST, axi.M_AXI_WDATA}, w_exp_q.pop_front());
        end
        if (gap_on && axi.M_AXI_ARVALID) begin
          if (axi.M_AXI_ARADDR == 8'h80) check("poll_gap_ge8", (gap_n >= 8), 1'b1);
          gap_on = 0;
        end else if (gap_on) begin
          gap_n++;
        end
        if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
          last_ar = axi.M_AXI_ARADDR;
          if (ar_exp_q.size() == 0) fail_now("ar_unexpected");
          else check("ar", axi.M_AXI_ARADDR, ar_exp_q.pop_front());
        end
        if (axi.M_AXI_RVALID && axi.M_AXI_RREADY && last_ar == 8'h80) begin
          gap_on = 1; gap_n = 0;
        end
        if (done) begin
          done_n++;
          if (p_done) fail_now("done_wider_than_one_cycle");
          if (done_exp_q.size() == 0) fail_now("done_unexpected");
          else check("done_status", {err_resp, err_timeout, result}, done_exp_q.pop_front());
        end
        p_av = axi.M_AXI_AWVALID; p_ar = axi.M_AXI_AWREADY; p_aa = axi.M_AXI_AWADDR;
        p_wv = axi.M_AXI_WVALID;  p_wr = axi.M_AXI_WREADY;
        p_wl = axi.M_AXI_WLAST;   p_wd = axi.M_AXI_WDATA;
        p_done = done;
      end
    end
  end

  // Driver tasks: inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic load_word(input logic [4:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_we = 1'b0;
    model_buf[a] = d;
  endtask

  task automatic push_writes(input logic [15:0] b);
    aw_exp_q.push_back({8'h00, 8'd31});
    for (int i = 0; i < 32; i++) w_exp_q.push_back({(i == 31), model_buf[i]});
    aw_exp_q.push_back({8'h8C, 8'd0}); w_exp_q.push_back({1'b1, 16'h0, b});
    aw_exp_q.push_back({8'h80, 8'd0}); w_exp_q.push_back({1'b1, 32'h1});
  endtask

  task automatic push_reads(input int polls);
    for (int i = 0; i < polls; i++) ar_exp_q.push_back(8'h80);
    ar_exp_q.push_back(8'h81);
  endtask

  task automatic pulse_start(input logic [15:0] b);
    bias_in = b; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t0;
    int k;
    t0 = done_n;
    k = 0;
    while (done_n == t0 && k < 4000) begin step(); k++; end
    if (k == 4000) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no done within 4000 cycles", name);
    end
    step();
    check({name, "_queues_drained"},
          aw_exp_q.size() + w_exp_q.size() + ar_exp_q.size() + done_exp_q.size(), 0);
  endtask

  initial begin : driver
    int k;
    rst = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0; bias_in = '0; start = 1'b0;
    repeat (3) step();
    check("rst_valids", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_WLAST,
          axi.M_AXI_BREADY, axi.M_AXI_ARVALID, axi.M_AXI_RREADY}, 6'b0);
    check("rst_addrs", {axi.M_AXI_AWADDR, axi.M_AXI_ARADDR}, 16'h0);
    check("rst_wdata", axi.M_AXI_WDATA, 32'h0);
    check("rst_status", {busy, done, err_resp, err_timeout}, 4'b0);
    check("rst_result", result, 16'h0);
    check("rst_state", dbg_state, 4'd0);
    check("const_fields", {axi.M_AXI_AWSIZE, axi.M_AXI_ARSIZE, axi.M_AXI_AWBURST,
          axi.M_AXI_ARBURST, axi.M_AXI_ARLEN, axi.M_AXI_WSTRB},
          {3'b010, 3'b010, 2'b01, 2'b01, 8'h00, 4'hF});
    rst = 1'b0;
    step();

    // Loopback: buf[i] = i, status done on the first poll
    for (int i = 0; i < 32; i++) load_word(5'(i), 32'(i));
    done_at = 1; res_val = 16'h1234;
    push_writes(16'h0005); push_reads(1); done_exp_q.push_back({2'b00, 16'h1234});
    pulse_start(16'h0005);
    wait_done("loopback");

    // MAC-style job: bf16 1.0 pairs everywhere, done on the third poll
    for (int i = 0; i < 32; i++) load_word(5'(i), 32'h3F80_3F80);
    done_at = 3; res_val = 16'h4188;
    push_writes(16'h0005); push_reads(3); done_exp_q.push_back({2'b00, 16'h4188});
    pulse_start(16'h0005);
    wait_done("mac_job");

    // Status never completes: 64 polls, then the result read anyway
    done_at = 0; res_val = 16'h00AA;
    push_writes(16'h0007); push_reads(64); done_exp_q.push_back({2'b01, 16'h00AA});
    pulse_start(16'h0007);
    wait_done("timeout");

    // Error response on the data burst: nothing after it, result held
    b_err_data = 1;
    aw_exp_q.push_back({8'h00, 8'd31});
    for (int i = 0; i < 32; i++) w_exp_q.push_back({(i == 31), model_buf[i]});
    done_exp_q.push_back({2'b10, 16'h00AA});
    pulse_start(16'h0009);
    wait_done("bresp_err");
    b_err_data = 0;

    // Backpressure, plus buffer writes and a start while busy
    aw_delay = 5; w_rand = 1; done_at = 1; res_val = 16'h0777;
    push_writes(16'h0011); push_reads(1); done_exp_q.push_back({2'b00, 16'h0777});
    pulse_start(16'h0011);
    step();
    ld_we = 1'b1; ld_addr = 5'd3; ld_data = 32'hDEAD_BEEF;
    step();
    ld_we = 1'b0;
    pulse_start(16'h0022);
    wait_done("backpressure");
    aw_delay = 0; w_rand = 0;

    // Reset at beat 10, then a clean rerun from beat 0
    push_writes(16'h0033);
    w_beats = 0;
    ld_we = 1'b1; ld_addr = 5'd5; ld_data = 32'h0BAD_0BAD;
    pulse_start(16'h0033);
    ld_we = 1'b0;
    k = 0;
    while (w_beats < 10 && k < 200) begin step(); k++; end
    check("reached_beat10", (w_beats >= 10), 1'b1);
    rst = 1'b1;
    step();
    check("mid_reset_idle", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY,
          axi.M_AXI_ARVALID, axi.M_AXI_RREADY, busy, done}, 7'b0);
    aw_exp_q.delete(); w_exp_q.delete(); ar_exp_q.delete(); done_exp_q.delete();
    rst = 1'b0;
    step();
    done_at = 2; res_val = 16'h0BEE;
    push_writes(16'h0044); push_reads(2); done_exp_q.push_back({2'b00, 16'h0BEE});
    pulse_start(16'h0044);
    repeat (4) step();
    pulse_start(16'h0055);
    wait_done("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mac_axi_master.md
# mac_axi_master

AXI-4 FULL initiator that drives one complete job on the MAC accelerator's slave port. It holds a local 32-word buffer of packed 16-bit inputs and weights and writes it as one 32-beat INCR burst to 0x00. It then writes the bias (0x8C) and the start bit (0x80), polls status (0x80) for done, and reads the 16-bit result (0x81). It sits between a local controller (CPU shim or test sequencer) and the accelerator's AXI slave.

## Interface
- C_M_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_M_AXI_ADDR_WIDTH, 8: AXI address width.
- POLL_MAX, 64: maximum status reads before timeout.
- POLL_GAP, 8: idle cycles between a status response and the next status AR.
- M_AXI_ACLK  in  1  single clock; all logic on the rising edge.
- M_AXI_ARESET  in  1  reset, synchronous and active-high.
- ld_we / ld_addr / ld_data  in  1/5/32  buffer write; ignored while busy.
- bias_in  in  16  sampled on accepted start.
- start  in  1  one-cycle pulse; ignored while busy.
- busy  out  1  high from accepted start until the cycle done is asserted.
- done  out  1  one-cycle pulse at end of job.
- result  out  16  RDATA[15:0] of the result read; held until the next done.
- err_resp  out  1  job ended on a non-OKAY BRESP/RRESP; valid with done, held until next start.
- err_timeout  out  1  POLL_MAX polls without the done bit; valid with done, held until next start.
- AW: M_AXI_AWADDR out 8, AWLEN out 8, AWSIZE out 3, AWBURST out 2, AWVALID out 1, AWREADY in 1.
- W: M_AXI_WDATA out 32, WSTRB out 4, WLAST out 1, WVALID out 1, WREADY in 1.
- B: M_AXI_BRESP in 2, BVALID in 1, BREADY out 1.
- AR: M_AXI_ARADDR out 8, ARLEN out 8, ARSIZE out 3, ARBURST out 2, ARVALID out 1, ARREADY in 1.
- R: M_AXI_RDATA in 32, RRESP in 2, RLAST in 1, RVALID in 1, RREADY out 1.

## Operation
- Buffer is 32x32: words 0-15 hold inputs, 16-31 hold weights, with the low half-word first. It is not cleared by reset.
- The following outputs are constant at all times:
  - AWSIZE=ARSIZE=3'b010.
  - AWBURST=ARBURST=2'b01.
  - ARLEN=0.
  - WSTRB=4'hF.
- FSM states: IDLE, D_AW, D_B, BI_AW, BI_B, ST_AW, ST_B, P_AR, P_R, P_GAP, R_AR, R_R, FIN.
- IDLE: on start, latch bias_in, clear err flags and counters, go to D_AW.
- Write phase entry (D_AW, BI_AW, ST_AW): assert AWVALID and WVALID in the same cycle and keep both asserted.
  - AWVALID drops the cycle after the AWREADY handshake.
  - WVALID stays high until the WLAST handshake.
  - The slave accepts an address only with WVALID present.
- Per-phase write content:
  - D_AW: AWADDR=0x00, AWLEN=31, WDATA=buf[beat]. beat advances only on WVALID&&WREADY. WLAST=1 only on beat 31.
  - BI_AW: AWADDR=0x8C, AWLEN=0, WDATA={16'h0,bias}, WLAST=1.
  - ST_AW: AWADDR=0x80, AWLEN=0, WDATA=32'h1, WLAST=1.
- *_B states: BREADY=1. On BVALID:
  - BRESP!=0: set err_resp and go to FIN.
  - Otherwise go to the next write phase, or to P_AR after ST_B.
- P_AR: ARADDR=0x80, ARVALID held until ARREADY.
- P_R: RREADY=1. On RVALID, increment poll_cnt, then:
  - RRESP!=0: set err_resp and go to FIN.
  - RDATA[1]=1: go to R_AR.
  - poll_cnt==POLL_MAX: set err_timeout and go to R_AR, because the result register persists.
  - Otherwise go to P_GAP for POLL_GAP cycles, then P_AR.
- R_AR/R_R: ARADDR=0x81, single-beat read. result<=RDATA[15:0]. RRESP!=0 sets err_resp. Go to FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Reset, including mid-transfer:
  - All VALID/READY outputs, busy, done, err flags, result and counters clear next edge.
  - FSM returns to IDLE.
  - The outstanding AXI transaction is abandoned.

## Timing
- Reset values: all AXI VALID/READY/LAST = 0, AWADDR=ARADDR=0, WDATA=0, busy=0, done=0, result=0, err_*=0.
- start sampled at edge N: busy=1 and AWVALID=WVALID=1 from edge N+1.
- The first write beat may complete in the same cycle as the AWREADY handshake.
- With zero-wait slave: each WREADY-high cycle transfers one beat.
- WDATA/WLAST/AWADDR/ARADDR stay stable while VALID is high and READY is low.
- done pulses exactly one cycle after the final R or B handshake.
- A start coincident with done is ignored, because busy is still high that cycle.
- ld_we in the same cycle as an accepted start writes nothing.

## Test plan
- Loopback: buf[i]=i, start -> one AW (0x00, LEN 31), 32 beats WDATA=0..31, WLAST only on beat 31, then AW 0x8C/WDATA 0x0005, then AW 0x80/WDATA 1.
- Against the MAC slave: inputs 1.0, weights 1.0 in bf16, bias 0x0005 -> done=1 for one cycle, result equals the slave's result register, err_*=0.
- BFM slave never sets the done bit -> exactly 64 status ARs at 0x80 with at least 8-cycle gaps, then one AR at 0x81, err_timeout=1, done pulse.
- BFM returns BRESP=2'b10 on the data burst -> no further AW/AR, err_resp=1, done one cycle later.
- Backpressure: AWREADY delayed 5 cycles and WREADY toggled pseudo-randomly -> AWVALID held, WDATA stable on stalls, 32 beats in order with no gaps.
- Reset asserted at write beat 10 -> all VALIDs 0 and busy 0 next cycle. A new start then repeats the full sequence from beat 0. start while busy is ignored.
